// File: rtl/seg_display_driver.sv
// seg_display_driver: turns the 32-bit Seg1Out word into eight multiplexed,
// active-low digits for a common-anode display. In hex mode each nibble is
// shown directly. In decimal mode a sequential double-dabble converter
// produces unsigned BCD, blanks leading zeros, and shows dashes when the
// value has more than eight decimal digits.
module seg_display_driver #(
  parameter int SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] SegData,
  input  logic        DecMode,
  output logic [7:0]  SegAn,
  output logic [7:0]  SegCode,
  output logic        Busy
);

  localparam int CNT_W = 20;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  // Scan state
  logic [CNT_W-1:0] r_scanCnt;
  logic [2:0]       r_idx;

  // Registered outputs
  logic [7:0] r_segAn;
  logic [7:0] r_segCode;
  logic       r_busy;

  // Converter and display state
  state_t      r_state;
  logic [31:0] r_bin;
  logic [39:0] r_bcd;
  logic [4:0]  r_count;
  logic [31:0] r_lastSrc;
  logic        r_prevDec;
  logic [31:0] r_nib;
  logic [7:0]  r_blank;
  logic        r_ovf;

  // Combinational helpers
  logic [39:0] w_bcdAdj;
  logic [7:0]  w_blank;
  logic        w_allZero;
  logic [3:0]  w_curNib;
  logic [7:0]  w_code;
  logic        w_start;

  assign SegAn   = r_segAn;
  assign SegCode = r_segCode;
  assign Busy    = r_busy;

  function automatic logic [7:0] hexSeg(input logic [3:0] n);
    logic [7:0] s;
    case (n)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

  // Double-dabble correction: add 3 to every BCD nibble that is 5 or more
  always_comb begin
    w_bcdAdj = r_bcd;
    for (int k = 0; k < 10; k++) begin
      if (r_bcd[4*k +: 4] >= 4'd5) begin
        w_bcdAdj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
      end
    end
  end

  // Leading-zero blanking: digit i is blank when it and every higher digit are zero
  always_comb begin
    w_blank   = 8'h00;
    w_allZero = 1'b1;
    for (int i = 7; i >= 1; i--) begin
      w_allZero  = w_allZero && (r_bcd[4*i +: 4] == 4'd0);
      w_blank[i] = w_allZero;
    end
  end

  // Segment pattern for the currently selected digit
  always_comb begin
    w_curNib = r_nib[4*r_idx +: 4];
    if (r_ovf) begin
      w_code = SEG_DASH;
    end else if (r_blank[r_idx]) begin
      w_code = SEG_BLANK;
    end else begin
      w_code = hexSeg(w_curNib);
    end
  end

  assign w_start = (SegData != r_lastSrc) || !r_prevDec;

  // Refresh counter: hold each digit for SCAN_DIV cycles, then move to the next
  always_ff @(posedge clk) begin
    if (reset) begin
      r_scanCnt <= '0;
      r_idx     <= 3'd0;
    end else if (r_scanCnt == CNT_MAX) begin
      r_scanCnt <= '0;
      r_idx     <= r_idx + 3'd1;
    end else begin
      r_scanCnt <= r_scanCnt + 1'b1;
    end
  end

  // Anode and segment outputs follow the digit index one cycle later
  always_ff @(posedge clk) begin
    if (reset) begin
      r_segAn   <= 8'hFF;
      r_segCode <= 8'hFF;
    end else begin
      r_segAn   <= ~(8'b1 << r_idx);
      r_segCode <= w_code;
    end
  end

  // Hex loading plus the decimal converter FSM; hex mode aborts any conversion
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_busy    <= 1'b0;
      r_bin     <= '0;
      r_bcd     <= '0;
      r_count   <= '0;
      r_lastSrc <= '0;
      r_prevDec <= 1'b0;
      r_nib     <= '0;
      r_blank   <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_prevDec <= DecMode;
      if (!DecMode) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
        r_nib   <= SegData;
        r_blank <= '0;
        r_ovf   <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_start) begin
              r_bin     <= SegData;
              r_bcd     <= '0;
              r_lastSrc <= SegData;
              r_count   <= '0;
              r_busy    <= 1'b1;
              r_state   <= SHIFT;
            end
          end
          SHIFT: begin
            {r_bcd, r_bin} <= {w_bcdAdj, r_bin} << 1;
            r_count        <= r_count + 5'd1;
            if (r_count == 5'd31) begin
              r_state <= DONE;
            end
          end
          DONE: begin
            r_ovf   <= |r_bcd[39:32];
            r_nib   <= r_bcd[31:0];
            r_blank <= w_blank;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seg_display_driver.sv
// tb_seg_display_driver: directed, table-driven checks of the 7-segment
// driver with a short scan period, plus hand-written multi-cycle sequences.
module tb_seg_display_driver;

  localparam int SCAN_DIV = 4;

  logic        clk;
  logic        reset;
  logic [31:0] SegData;
  logic        DecMode;
  logic [7:0]  SegAn;
  logic [7:0]  SegCode;
  logic        Busy;

  int nVec;
  int nFail;

  logic [7:0] seen [8];

  typedef struct {
    logic [31:0] data;
    logic        dec;
    logic [7:0]  exp [8];
  } vec_t;

  vec_t vecs [11];

  seg_display_driver #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk    (clk),
    .reset  (reset),
    .SegData(SegData),
    .DecMode(DecMode),
    .SegAn  (SegAn),
    .SegCode(SegCode),
    .Busy   (Busy)
  );

  // Free-running 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] data, input logic dec);
    @(negedge clk);
    SegData = data;
    DecMode = dec;
  endtask

  // Wait (bounded) for Busy to be low at a falling edge
  task automatic waitBusyLow(input string name);
    int n;
    n = 0;
    while (Busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (Busy) begin
      nVec++;
      nFail++;
      $display("[TB] FAIL %s: Busy still 1 after %0d cycles, expected 0", name, n);
    end
  endtask

  // Record the segment code seen for each digit over a window of cycles
  task automatic captureDigits(input int cycles);
    logic [7:0] an;
    for (int i = 0; i < 8; i++) seen[i] = 8'h00;
    repeat (cycles) begin
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        an = ~(8'b1 << i);
        if (SegAn == an) seen[i] = SegCode;
      end
    end
  endtask

  initial begin
    nVec    = 0;
    nFail   = 0;
    reset   = 1'b1;
    SegData = 32'h0;
    DecMode = 1'b0;

    vecs[0]  = '{32'h1234ABCD, 1'b0, '{8'hA1, 8'hC6, 8'h83, 8'h88, 8'h99, 8'hB0, 8'hA4, 8'hF9}};
    vecs[1]  = '{32'd12345,    1'b1, '{8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hFF, 8'hFF, 8'hFF}};
    vecs[2]  = '{32'd0,        1'b1, '{8'hC0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF}};
    vecs[3]  = '{32'd100000000, 1'b1, '{8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF}};
    vecs[4]  = '{32'd99999999, 1'b1, '{8'h90, 8'h90, 8'h90, 8'h90, 8'h90, 8'h90, 8'h90, 8'h90}};
    vecs[5]  = '{32'h00000000, 1'b0, '{8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0}};
    vecs[6]  = '{32'd10,       1'b1, '{8'hC0, 8'hF9, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF}};
    vecs[7]  = '{32'hFFFFFFFF, 1'b1, '{8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF}};
    vecs[8]  = '{32'hFEDCBA98, 1'b0, '{8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E}};
    vecs[9]  = '{32'd87654321, 1'b1, '{8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80}};
    vecs[10] = '{32'd1000,     1'b1, '{8'hC0, 8'hC0, 8'hC0, 8'hF9, 8'hFF, 8'hFF, 8'hFF, 8'hFF}};

    // Reset state, then digit 0 on the first cycle after release
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("resetSegAn", {24'h0, SegAn}, 32'hFF);
    checkOutput("resetSegCode", {24'h0, SegCode}, 32'hFF);
    checkOutput("resetBusy", {31'h0, Busy}, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("firstSegAn", {24'h0, SegAn}, 32'hFE);
    checkOutput("firstSegCode", {24'h0, SegCode}, 32'hC0);

    // Scan order and dwell: each anode held exactly SCAN_DIV cycles
    applyStimulus(32'h1234ABCD, 1'b0);
    begin
      int n;
      n = 0;
      while (SegAn != 8'h7F && n < 64) begin @(negedge clk); n++; end
      while (SegAn != 8'hFE && n < 128) begin @(negedge clk); n++; end
      if (SegAn != 8'hFE) begin
        nVec++;
        nFail++;
        $display("[TB] FAIL scanSync: SegAn %0h, expected fe", SegAn);
      end else begin
        for (int k = 0; k < 8 * SCAN_DIV; k++) begin
          logic [7:0] expAn;
          expAn = ~(8'b1 << (k / SCAN_DIV));
          checkOutput($sformatf("scanAn[%0d]", k), {24'h0, SegAn}, {24'h0, expAn});
          @(negedge clk);
        end
      end
    end

    // Table-driven vectors
    for (int v = 0; v < 11; v++) begin
      applyStimulus(vecs[v].data, vecs[v].dec);
      @(negedge clk);
      waitBusyLow($sformatf("vec%0dBusy", v));
      repeat (2) @(negedge clk);
      captureDigits(34);
      for (int i = 0; i < 8; i++) begin
        checkOutput($sformatf("vec%0dDigit%0d", v, i), {24'h0, seen[i]}, {24'h0, vecs[v].exp[i]});
      end
    end

    // Busy stays high for exactly 33 cycles
    applyStimulus(32'h0, 1'b0);
    repeat (3) @(negedge clk);
    applyStimulus(32'd12345, 1'b1);
    begin
      int cnt;
      cnt = 0;
      for (int n = 0; n < 100; n++) begin
        @(negedge clk);
        if (Busy) cnt++;
        else if (cnt > 0) break;
      end
      checkOutput("busyCycles", cnt, 33);
    end
    repeat (2) @(negedge clk);
    captureDigits(34);
    checkOutput("busySeqDigit0", {24'h0, seen[0]}, 32'h92);
    checkOutput("busySeqDigit5", {24'h0, seen[5]}, 32'hFF);

    // Input change mid-conversion: first value committed, then restart
    applyStimulus(32'd5, 1'b1);
    repeat (11) @(posedge clk);
    @(negedge clk);
    SegData = 32'd7;
    checkOutput("midBusy", {31'h0, Busy}, 32'h1);
    waitBusyLow("midWait");
    @(negedge clk);
    checkOutput("restartBusy", {31'h0, Busy}, 32'h1);
    captureDigits(32);
    checkOutput("firstCommitDigit0", {24'h0, seen[0]}, 32'h92);
    checkOutput("firstCommitDigit1", {24'h0, seen[1]}, 32'hFF);
    waitBusyLow("secondWait");
    repeat (2) @(negedge clk);
    captureDigits(34);
    checkOutput("secondCommitDigit0", {24'h0, seen[0]}, 32'hF8);
    checkOutput("secondCommitDigit7", {24'h0, seen[7]}, 32'hFF);

    // Reset in the middle of a conversion
    applyStimulus(32'd999, 1'b1);
    repeat (5) @(negedge clk);
    checkOutput("preResetBusy", {31'h0, Busy}, 32'h1);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midResetBusy", {31'h0, Busy}, 32'h0);
    checkOutput("midResetSegAn", {24'h0, SegAn}, 32'hFF);
    checkOutput("midResetSegCode", {24'h0, SegCode}, 32'hFF);
    DecMode = 1'b0;
    SegData = 32'h0;
    reset   = 1'b0;
    repeat (3) @(negedge clk);
    captureDigits(34);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("postResetDigit%0d", i), {24'h0, seen[i]}, 32'hC0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule
